// File: rtl/ddr2axis_pkg.sv
// Shared AXI encodings, sizing helpers and derived frame geometry for the DDR frame reader.
// Functions give geometry for any parameter set; the localparams give it for the default build.
package ddr2axis_pkg;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

    // Bits needed to hold bit_depth (so clogb2(16) = 5).
    function automatic int clogb2(input int bit_depth);
        int d;
        int r;
        d = bit_depth;
        r = 0;
        while (d > 0) begin
            r++;
            d = d >> 1;
        end
        return r;
    endfunction

    function automatic int f_burst_bytes(input int burst_len, input int data_w);
        return burst_len * data_w / 8;
    endfunction

    function automatic int f_words_per_beat(input int data_w, input int tdata_w);
        return data_w / tdata_w;
    endfunction

    function automatic int f_frame_bursts(input int frame_beats, input int burst_len);
        return frame_beats / burst_len;
    endfunction

    function automatic int f_frame_bytes(input int frame_beats, input int data_w);
        return frame_beats * data_w / 8;
    endfunction

    localparam int DEF_BURST_LEN   = 16;
    localparam int DEF_DATA_WIDTH  = 128;
    localparam int DEF_TDATA_WIDTH = 32;
    localparam int DEF_FRAME_BEATS = 64;

    localparam int BURST_BYTES    = f_burst_bytes(DEF_BURST_LEN, DEF_DATA_WIDTH);
    localparam int WORDS_PER_BEAT = f_words_per_beat(DEF_DATA_WIDTH, DEF_TDATA_WIDTH);
    localparam int FRAME_BURSTS   = f_frame_bursts(DEF_FRAME_BEATS, DEF_BURST_LEN);
    localparam int FRAME_BYTES    = f_frame_bytes(DEF_FRAME_BEATS, DEF_DATA_WIDTH);

endpackage

// File: rtl/ddr2axis_rd_if.sv
// AXI4 read-channel plus AXI-Stream bundle of the frame reader.
// master = the reader (drives AR, RREADY, stream); slave = memory and stream sink.
interface ddr2axis_rd_if #(
    parameter int ID_W    = 1,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128,
    parameter int TDATA_W = 32
);
    logic [ID_W-1:0]      M_AXI_ARID;
    logic [ADDR_W-1:0]    M_AXI_ARADDR;
    logic [7:0]           M_AXI_ARLEN;
    logic [2:0]           M_AXI_ARSIZE;
    logic [1:0]           M_AXI_ARBURST;
    logic                 M_AXI_ARLOCK;
    logic [3:0]           M_AXI_ARCACHE;
    logic [2:0]           M_AXI_ARPROT;
    logic [3:0]           M_AXI_ARQOS;
    logic                 M_AXI_ARVALID;
    logic                 M_AXI_ARREADY;
    logic [ID_W-1:0]      M_AXI_RID;
    logic [DATA_W-1:0]    M_AXI_RDATA;
    logic [1:0]           M_AXI_RRESP;
    logic                 M_AXI_RLAST;
    logic                 M_AXI_RVALID;
    logic                 M_AXI_RREADY;
    logic                 M_AXIS_TVALID;
    logic [TDATA_W-1:0]   M_AXIS_TDATA;
    logic [TDATA_W/8-1:0] M_AXIS_TSTRB;
    logic                 M_AXIS_TLAST;
    logic                 M_AXIS_TUSER;
    logic                 M_AXIS_TREADY;

    modport master (
        output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
               M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARVALID,
               M_AXI_RREADY,
               M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST, M_AXIS_TUSER,
        input  M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
               M_AXI_RVALID, M_AXIS_TREADY
    );

    modport slave (
        input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
               M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARVALID,
               M_AXI_RREADY,
               M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST, M_AXIS_TUSER,
        output M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
               M_AXI_RVALID, M_AXIS_TREADY
    );
endinterface

// File: rtl/ddr2axis_rd_axis_downsizer.sv
// Splits wide read beats into LSB-first stream words and tags SOF (TUSER) / EOF (TLAST).
// Latency: first word valid 1 cycle after the beat is accepted; full throughput back-to-back.
// Backpressure: word held stable until tready; a new beat is taken only when empty or on the last word's pop.
module axis_downsizer
    import ddr2axis_pkg::*;
#(
    parameter int IN_W        = 128,
    parameter int OUT_W       = 32,
    parameter int FRAME_BEATS = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             in_vld,
    input  logic [IN_W-1:0]  in_dat,
    output logic             in_rdy,
    output logic             tvalid,
    output logic [OUT_W-1:0] tdata,
    output logic             tuser,
    output logic             tlast,
    input  logic             tready,
    output logic             drained
);
    localparam int R  = f_words_per_beat(IN_W, OUT_W);
    localparam int IW = (R > 1) ? $clog2(R) : 1;
    localparam int BW = $clog2(FRAME_BEATS + 1);

    logic [IN_W-1:0] hold_dat;
    logic            hold_vld;
    logic [IW-1:0]   word_idx;
    logic [BW-1:0]   load_cnt;
    logic [BW-1:0]   hold_beat;
    logic            last_word;
    logic            pop;
    logic            pop_last;
    logic            load;

    assign last_word = (word_idx == IW'(R - 1));
    assign pop       = hold_vld && tready;
    assign pop_last  = pop && last_word;
    assign in_rdy    = en && (!hold_vld || pop_last);
    assign load      = in_rdy && in_vld;
    assign drained   = !hold_vld || pop_last;

    assign tvalid = hold_vld;
    assign tdata  = hold_dat[OUT_W*int'(word_idx) +: OUT_W];
    // Markers follow the beat count within the frame, not RLAST.
    assign tuser  = hold_vld && (hold_beat == '0) && (word_idx == '0);
    assign tlast  = hold_vld && (hold_beat == BW'(FRAME_BEATS - 1)) && last_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_dat  <= '0;
            hold_vld  <= 1'b0;
            word_idx  <= '0;
            load_cnt  <= '0;
            hold_beat <= '0;
        end else begin
            if (clr) begin
                load_cnt <= '0;
            end
            if (load) begin
                hold_dat  <= in_dat;
                hold_vld  <= 1'b1;
                word_idx  <= '0;
                hold_beat <= load_cnt;
                load_cnt  <= load_cnt + BW'(1);
            end else if (pop) begin
                if (last_word) begin
                    hold_vld <= 1'b0;
                    word_idx <= '0;
                end else begin
                    word_idx <= word_idx + IW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/ddr2axis_rd.sv
// AXI4 read master replaying one DDR frame as an AXI-Stream; optional DDR2AXIS_PINGPONG_EN alternates two buffers.
// Latency: first stream word 1 cycle after the first R handshake; one outstanding burst at a time.
// Backpressure: TREADY stalls the downsizer, which holds RREADY low; frame_start is ignored while busy.
module ddr2axis_rd
    import ddr2axis_pkg::*;
#(
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h10000000,
    parameter int C_M_AXI_BURST_LEN    = 16,
    parameter int C_M_AXI_ID_WIDTH     = 1,
    parameter int C_M_AXI_ADDR_WIDTH   = 32,
    parameter int C_M_AXI_DATA_WIDTH   = 128,
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int C_FRAME_BEATS        = 64
) (
    input  logic M_AXI_ACLK,
    input  logic M_AXI_ARESETN,
    input  logic frame_start,
    output logic busy,
    output logic rd_error,
    ddr2axis_rd_if.master bus
);
    localparam int AW     = C_M_AXI_ADDR_WIDTH;
    localparam int NBURST = f_frame_bursts(C_FRAME_BEATS, C_M_AXI_BURST_LEN);
    localparam int CW     = (NBURST > 1) ? $clog2(NBURST) : 1;

    localparam logic [AW-1:0] BASE       = AW'(C_M_TARGET_SLAVE_BASE_ADDR);
    localparam logic [AW-1:0] BURST_STEP = AW'(f_burst_bytes(C_M_AXI_BURST_LEN, C_M_AXI_DATA_WIDTH));
    localparam logic [AW-1:0] BUF_STEP   = AW'(f_frame_bytes(C_FRAME_BEATS, C_M_AXI_DATA_WIDTH));

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADDR  = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]    state;
    logic [AW-1:0] araddr;
    logic [CW-1:0] burst_cnt;
    logic [AW-1:0] frame_base;
    logic          start_acc;
    logic          r_hs;
    logic          ds_drained;
    logic          unused_rid;

    assign start_acc  = (state == ST_IDLE) && frame_start;
    assign r_hs       = bus.M_AXI_RVALID && bus.M_AXI_RREADY;
    assign unused_rid = ^bus.M_AXI_RID;

`ifdef DDR2AXIS_PINGPONG_EN
    logic buf_sel;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            buf_sel <= 1'b0;
        end else if (start_acc) begin
            buf_sel <= ~buf_sel;
        end
    end

    assign frame_base = buf_sel ? (BASE + BUF_STEP) : BASE;
`else
    assign frame_base = BASE;
`endif

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state     <= ST_IDLE;
            araddr    <= BASE;
            burst_cnt <= '0;
            busy      <= 1'b0;
            rd_error  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        state     <= ST_ADDR;
                        araddr    <= frame_base;
                        burst_cnt <= '0;
                        busy      <= 1'b1;
                        rd_error  <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (bus.M_AXI_ARREADY) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_hs && (bus.M_AXI_RRESP != RESP_OKAY)) begin
                        rd_error <= 1'b1;
                    end
                    // Burst boundaries follow RLAST even if the slave miscounts beats.
                    if (r_hs && bus.M_AXI_RLAST) begin
                        if (burst_cnt == CW'(NBURST - 1)) begin
                            state <= ST_DRAIN;
                        end else begin
                            araddr    <= araddr + BURST_STEP;
                            burst_cnt <= burst_cnt + CW'(1);
                            state     <= ST_ADDR;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (ds_drained) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.M_AXI_ARID    = '0;
    assign bus.M_AXI_ARADDR  = araddr;
    assign bus.M_AXI_ARLEN   = 8'(C_M_AXI_BURST_LEN - 1);
    assign bus.M_AXI_ARSIZE  = 3'(clogb2(C_M_AXI_DATA_WIDTH / 8) - 1);
    assign bus.M_AXI_ARBURST = BURST_INCR;
    assign bus.M_AXI_ARLOCK  = 1'b0;
    assign bus.M_AXI_ARCACHE = CACHE_DEFAULT;
    assign bus.M_AXI_ARPROT  = 3'b000;
    assign bus.M_AXI_ARQOS   = 4'b0000;
    assign bus.M_AXI_ARVALID = (state == ST_ADDR);
    assign bus.M_AXIS_TSTRB  = '1;

    axis_downsizer #(
        .IN_W        (C_M_AXI_DATA_WIDTH),
        .OUT_W       (C_M_AXIS_TDATA_WIDTH),
        .FRAME_BEATS (C_FRAME_BEATS)
    ) u_downsizer (
        .clk     (M_AXI_ACLK),
        .rst_n   (M_AXI_ARESETN),
        .clr     (start_acc),
        .en      (state == ST_DATA),
        .in_vld  (bus.M_AXI_RVALID),
        .in_dat  (bus.M_AXI_RDATA),
        .in_rdy  (bus.M_AXI_RREADY),
        .tvalid  (bus.M_AXIS_TVALID),
        .tdata   (bus.M_AXIS_TDATA),
        .tuser   (bus.M_AXIS_TUSER),
        .tlast   (bus.M_AXIS_TLAST),
        .tready  (bus.M_AXIS_TREADY),
        .drained (ds_drained)
    );
endmodule

// File: doc/ddr2axis_rd.md
Name: ddr2axis_rd

Overview:
- AXI4-full read master that fetches one frame from DDR and replays it as a 32-bit AXI-Stream.
- Downstream (read-back) counterpart of axis2ddr_top: reads the frame buffer that block writes at the same base address, with the same burst geometry.
- Feeds display/check logic.
- Read channels only; no write channels.

Parameters:
- C_M_TARGET_SLAVE_BASE_ADDR, 32'h10000000, byte address of frame buffer 0.
- C_M_AXI_BURST_LEN, 16, beats per burst (1..256, power of 2).
- C_M_AXI_ID_WIDTH, 1, ARID/RID width.
- C_M_AXI_ADDR_WIDTH, 32, address width.
- C_M_AXI_DATA_WIDTH, 128, AXI data width.
- C_M_AXIS_TDATA_WIDTH, 32, stream width; must divide C_M_AXI_DATA_WIDTH.
- C_FRAME_BEATS, 64, AXI beats per frame; must be a multiple of C_M_AXI_BURST_LEN.

Ports:
- M_AXI_ACLK, in, 1, sole clock.
- M_AXI_ARESETN, in, 1, asynchronous active-low reset.
- frame_start, in, 1, one-cycle pulse that begins a frame read.
- busy, out, 1, high from accepted start until the last stream word is accepted.
- rd_error, out, 1, sticky; set on any RRESP != 2'b00; cleared by an accepted start.
- M_AXI_ARID, out, C_M_AXI_ID_WIDTH, constant 0.
- M_AXI_ARADDR, out, C_M_AXI_ADDR_WIDTH, burst address.
- M_AXI_ARLEN, out, 8, C_M_AXI_BURST_LEN-1.
- M_AXI_ARSIZE, out, 3, clogb2(C_M_AXI_DATA_WIDTH/8)-1.
- M_AXI_ARBURST, out, 2, 2'b01 (INCR).
- M_AXI_ARLOCK, out, 1, 0.
- M_AXI_ARCACHE, out, 4, 4'b0011.
- M_AXI_ARPROT, out, 3, 0.
- M_AXI_ARQOS, out, 4, 0.
- M_AXI_ARVALID, out, 1, address valid.
- M_AXI_ARREADY, in, 1, address ready.
- M_AXI_RID, in, C_M_AXI_ID_WIDTH, ignored.
- M_AXI_RDATA, in, C_M_AXI_DATA_WIDTH, read data.
- M_AXI_RRESP, in, 2, read response.
- M_AXI_RLAST, in, 1, last beat of burst.
- M_AXI_RVALID, in, 1, data valid.
- M_AXI_RREADY, out, 1, data ready.
- M_AXIS_TVALID, out, 1, stream valid.
- M_AXIS_TDATA, out, C_M_AXIS_TDATA_WIDTH, stream word.
- M_AXIS_TSTRB, out, C_M_AXIS_TDATA_WIDTH/8, all ones.
- M_AXIS_TLAST, out, 1, last word of frame.
- M_AXIS_TUSER, out, 1, first word of frame (SOF).
- M_AXIS_TREADY, in, 1, stream ready.

Behaviour:
- Reset values: all outputs 0; ARADDR = base; FSM in IDLE; holding register empty.
- FSM states:
  - IDLE: frame_start -> ADDR. Latch address = base, clear burst counter, clear rd_error, busy<=1. frame_start outside IDLE is ignored.
  - ADDR: ARVALID=1, ARADDR stable. On ARVALID&&ARREADY -> DATA; ARVALID deasserts next cycle.
  - DATA: accept beats. On RVALID&&RREADY&&RLAST:
    - if burst counter == C_FRAME_BEATS/C_M_AXI_BURST_LEN-1 -> DRAIN;
    - else ARADDR += C_M_AXI_BURST_LEN*C_M_AXI_DATA_WIDTH/8 (256 at defaults), counter++, -> ADDR.
  - DRAIN: wait until the last stream word is accepted, then busy<=0 -> IDLE.
- Outstanding bursts: exactly one at a time. No 4KB boundary check; base plus burst alignment guarantees none is crossed.
- Downsizer: one C_M_AXI_DATA_WIDTH holding register plus a word index (ratio R = 4 at defaults).
  - RREADY = holding register empty, OR (TVALID && TREADY && index == R-1), and state == DATA.
  - An RDATA beat is split LSB-first; word k = RDATA[32k+31:32k].
  - TVALID is held until TREADY. TDATA/TUSER/TLAST stay stable while stalled.
  - Back-to-back beats with TREADY=1 give 100% stream throughput, no bubble.
- Latency: first TVALID 1 cycle after the first R handshake.
- Stream markers:
  - TUSER=1 only on word 0 of beat 0 of the frame.
  - TLAST=1 only on word R-1 of beat C_FRAME_BEATS-1.
  - Total words per frame = C_FRAME_BEATS*R.
- Errors: RRESP error sets rd_error, but data still streams and the frame completes; no abort.
- RLAST arriving early or late vs the beat count: the FSM follows RLAST. The beat counter, not RLAST, drives TLAST.
- Asynchronous reset mid-frame: everything returns to reset values immediately; no partial-frame recovery.

Optional Feature:
- Macro: DDR2AXIS_PINGPONG_EN.
- Defined: an internal buffer-select bit toggles at each accepted frame_start. The frame base alternates between C_M_TARGET_SLAVE_BASE_ADDR and base + C_FRAME_BEATS*C_M_AXI_DATA_WIDTH/8. The first frame after reset uses buffer 0.
- Undefined: every frame reads from C_M_TARGET_SLAVE_BASE_ADDR; the select bit is absent.

Decomposition:
- Package ddr2axis_pkg holds:
  - AXI encodings: BURST_INCR, RESP_OKAY, CACHE_DEFAULT;
  - the clogb2 function;
  - derived constants: BURST_BYTES, WORDS_PER_BEAT, FRAME_BURSTS, FRAME_BYTES.
- One sub-module: axis_downsizer, which contains the holding register, word index and SOF/EOF tagging.
- The FSM and address counter stay in ddr2axis_rd.

Test Plan:
- Default params, memory preloaded with incrementing 32-bit words from 0x10000000, TREADY=1 -> 4 ARs at 0x10000000/100/200/300, ARLEN=15, ARSIZE=4; 256 stream words 0..255; TUSER on word 0 only; TLAST on word 255 only; busy low after the last word.
- TREADY random 50% -> same 256 words in order; TDATA stable while TVALID&&!TREADY; RREADY never high while holding is full and not draining.
- Memory RRESP=2'b10 on beat 20 -> rd_error=1 after that beat; all 256 words still delivered; next frame_start clears rd_error.
- frame_start pulsed during the busy frame -> ignored; exactly 4 ARs, no extra frame.
- Reset asserted mid-burst at beat 30 -> ARVALID, RREADY, TVALID and busy go 0 immediately; a fresh frame_start after reset reads from 0x10000000.
- With DDR2AXIS_PINGPONG_EN, two frames -> first ARADDR 0x10000000, second 0x10000400.
